// File: rtl/alarm_arbiter.sv
// alarm_arbiter: confirms anomalies by hit persistence, latches an alarm with a one-shot irq, releases
// on ack plus a sustained clear run, then holds off re-arming for a cooldown. ALARM_PEAK_EN adds peak_vote tracking.
module alarm_arbiter #(
  parameter int VOTE_THRESH  = 25,
  parameter int CONFIRM_CNT  = 3,
  parameter int CLEAR_CNT    = 4,
  parameter int COOLDOWN_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic [5:0] vote_count,
  input  logic       anomaly_detected,
  input  logic       ack,
  output logic       alarm,
  output logic       alarm_irq,
  output logic [1:0] alarm_state,
  output logic [7:0] event_count,
  output logic [5:0] peak_vote
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SUSPECT  = 2'd1,
    ST_ALARM    = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  localparam logic [5:0]  THRESH  = 6'(VOTE_THRESH);
  localparam logic [3:0]  CONFIRM = 4'(CONFIRM_CNT);
  localparam logic [3:0]  CLEAR   = 4'(CLEAR_CNT);
  localparam logic [15:0] CD_LAST = 16'(COOLDOWN_CYC - 1);

  state_t      state, state_nxt;
  logic [3:0]  hit_cnt, hit_cnt_nxt;
  logic [3:0]  clr_cnt, clr_cnt_nxt;
  logic [15:0] cd_cnt, cd_cnt_nxt;
  logic        ack_lat, ack_lat_nxt;
  logic [7:0]  event_nxt;
  logic        enter_alarm;
  logic        ack_v;
  logic [3:0]  clr_v;
  logic        hit, miss;

  assign hit  = data_valid & anomaly_detected & (vote_count >= THRESH);
  assign miss = data_valid & ~hit;

  always_comb begin
    state_nxt   = state;
    hit_cnt_nxt = hit_cnt;
    clr_cnt_nxt = clr_cnt;
    cd_cnt_nxt  = cd_cnt;
    ack_lat_nxt = ack_lat;
    event_nxt   = event_count;
    enter_alarm = 1'b0;
    ack_v       = 1'b0;
    clr_v       = 4'd0;
    case (state)
      ST_IDLE, ST_SUSPECT: begin
        if (hit) begin
          if (hit_cnt + 4'd1 >= CONFIRM) begin
            enter_alarm = 1'b1;
            state_nxt   = ST_ALARM;
            hit_cnt_nxt = 4'd0;
            clr_cnt_nxt = 4'd0;
            ack_lat_nxt = 1'b0;
            if (event_count != 8'hff) event_nxt = event_count + 8'd1;
          end else begin
            state_nxt   = ST_SUSPECT;
            hit_cnt_nxt = hit_cnt + 4'd1;
          end
        end else if (miss) begin
          state_nxt   = ST_IDLE;
          hit_cnt_nxt = 4'd0;
        end
      end
      ST_ALARM: begin
        // Release uses this cycle's ack and sample, so an ack after the clear run exits immediately.
        ack_v = ack_lat | ack;
        if (hit)
          clr_v = 4'd0;
        else if (miss && clr_cnt != CLEAR)
          clr_v = clr_cnt + 4'd1;
        else
          clr_v = clr_cnt;
        ack_lat_nxt = ack_v;
        clr_cnt_nxt = clr_v;
        if (clr_v == CLEAR && ack_v) begin
          state_nxt   = ST_COOLDOWN;
          cd_cnt_nxt  = 16'd0;
          clr_cnt_nxt = 4'd0;
          ack_lat_nxt = 1'b0;
        end
      end
      ST_COOLDOWN: begin
        if (cd_cnt == CD_LAST) begin
          state_nxt  = ST_IDLE;
          cd_cnt_nxt = 16'd0;
        end else begin
          cd_cnt_nxt = cd_cnt + 16'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      hit_cnt     <= 4'd0;
      clr_cnt     <= 4'd0;
      cd_cnt      <= 16'd0;
      ack_lat     <= 1'b0;
      event_count <= 8'd0;
      alarm       <= 1'b0;
      alarm_irq   <= 1'b0;
    end else begin
      state       <= state_nxt;
      hit_cnt     <= hit_cnt_nxt;
      clr_cnt     <= clr_cnt_nxt;
      cd_cnt      <= cd_cnt_nxt;
      ack_lat     <= ack_lat_nxt;
      event_count <= event_nxt;
      alarm       <= (state_nxt == ST_ALARM);
      alarm_irq   <= enter_alarm;
    end
  end

  assign alarm_state = state;

`ifdef ALARM_PEAK_EN
  logic [5:0] peak_q;

  // Peak restarts from the confirming sample and is held after release until the next episode.
  always_ff @(posedge clk) begin
    if (rst)
      peak_q <= 6'd0;
    else if (enter_alarm)
      peak_q <= vote_count;
    else if (state == ST_ALARM && data_valid && vote_count > peak_q)
      peak_q <= vote_count;
  end

  assign peak_vote = peak_q;
`else
  assign peak_vote = 6'd0;
`endif

endmodule

// File: tb/tb_alarm_arbiter.sv
// Scoreboard bench for alarm_arbiter: directed episodes then biased random traffic against a reference model.
module tb_alarm_arbiter;

  localparam int THRESH   = 25;
  localparam int CONFIRM  = 3;
  localparam int CLEAR    = 4;
  localparam int COOLDOWN = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_valid = 1'b0;
  logic [5:0] vote_count = 6'd0;
  logic       anomaly_detected = 1'b0;
  logic       ack = 1'b0;
  logic       alarm, alarm_irq;
  logic [1:0] alarm_state;
  logic [7:0] event_count;
  logic [5:0] peak_vote;

  alarm_arbiter dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .vote_count(vote_count),
    .anomaly_detected(anomaly_detected), .ack(ack), .alarm(alarm), .alarm_irq(alarm_irq),
    .alarm_state(alarm_state), .event_count(event_count), .peak_vote(peak_vote)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [17:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: mode uses the output encoding; runs are plain unbounded integers.
  int m_mode = 0, m_run = 0, m_quiet = 0, m_entry = 0, m_events = 0, m_peak = 0;
  bit m_acked = 0, m_irq = 0;

  task automatic model_step(input bit dv, input int vote, input bit flag, input bit ak,
                            input bit r, input int tgt);
    bit   hit, miss;
    exp_t e;
    if (r) begin
      m_mode = 0; m_run = 0; m_quiet = 0; m_events = 0; m_peak = 0; m_acked = 0; m_irq = 0;
    end else begin
      hit   = dv && flag && (vote >= THRESH);
      miss  = dv && !hit;
      m_irq = 0;
      case (m_mode)
        0, 1: begin
          if (hit) begin
            m_run++;
            if (m_run >= CONFIRM) begin
              m_mode = 2; m_irq = 1; m_acked = 0; m_quiet = 0; m_run = 0; m_peak = vote;
              if (m_events < 255) m_events++;
            end else m_mode = 1;
          end else if (miss) begin
            m_run = 0; m_mode = 0;
          end
        end
        2: begin
          if (ak) m_acked = 1;
          if (hit) m_quiet = 0;
          else if (miss) m_quiet++;
          if (dv && vote > m_peak) m_peak = vote;
          if (m_quiet >= CLEAR && m_acked) begin
            m_mode = 3; m_entry = tgt;
          end
        end
        default: if (tgt - m_entry >= COOLDOWN) m_mode = 0;
      endcase
    end
    e.cyc = tgt;
`ifdef ALARM_PEAK_EN
    e.v = {m_mode == 2, m_irq, 2'(m_mode), 8'(m_events), 6'(m_peak)};
`else
    e.v = {m_mode == 2, m_irq, 2'(m_mode), 8'(m_events), 6'd0};
`endif
    sb.push_back(e);
  endtask

  task automatic drive(input bit dv, input int vote, input bit flag, input bit ak, input bit r);
    @(posedge clk);
    #1;
    data_valid = dv; vote_count = 6'(vote); anomaly_detected = flag; ack = ak; rst = r;
    model_step(dv, vote, flag, ak, r, cyc + 1);
  endtask

  task automatic smp(input int vote, input bit flag);
    drive(1'b1, vote, flag, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  exp_t        got;
  logic [17:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      got = sb.pop_front();
      act = {alarm, alarm_irq, alarm_state, event_count, peak_vote};
      n_checks++;
      if (got.cyc != cyc || act !== got.v) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d: got alarm=%b irq=%b state=%0d events=%0d peak=%0d, want alarm=%b irq=%b state=%0d events=%0d peak=%0d (slot %0d)",
                 cyc, act[17], act[16], act[15:14], act[13:6], act[5:0],
                 got.v[17], got.v[16], got.v[15:14], got.v[13:6], got.v[5:0], got.cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    bit hot;
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // Three hits confirm; alarm and one-shot irq follow the third sample.
    smp(45, 1'b1); idle(1); smp(45, 1'b1); smp(45, 1'b1);
    idle(3);
    // Clear run without ack holds the alarm; ack then releases into a full cooldown that ignores hits.
    for (int i = 0; i < 4; i++) smp(2, 1'b1);
    idle(3);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(2);
    for (int i = 0; i < 5; i++) smp(45, 1'b1);
    idle(COOLDOWN);
    // Interrupted suspect run, then threshold boundary and flag gating.
    smp(45, 1'b1); smp(45, 1'b1); smp(2, 1'b1); idle(2);
    for (int i = 0; i < 5; i++) smp(24, 1'b1);
    for (int i = 0; i < 4; i++) smp(50, 1'b0);
    smp(25, 1'b1); smp(25, 1'b1); smp(25, 1'b1);
    idle(2);
    // Ack first, a hit breaks the clear run; release only on the fourth fresh miss.
    drive(1'b1, 3, 1'b1, 1'b1, 1'b0);
    smp(3, 1'b1); smp(3, 1'b1); smp(45, 1'b1);
    for (int i = 0; i < 3; i++) smp(3, 1'b1);
    idle(2);
    smp(3, 1'b1);
    idle(COOLDOWN + 3);
    // Peak tracking across an episode, then reset mid-alarm.
    smp(30, 1'b1); smp(30, 1'b1); smp(30, 1'b1);
    smp(45, 1'b1); smp(40, 1'b1); idle(2);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(3);
    // Biased random traffic with occasional ack and reset.
    hot = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      bit dv, flag, ak, r;
      int vote;
      if (i % 40 == 0) hot = ($urandom_range(0, 2) != 0);
      dv   = ($urandom_range(0, 3) != 0);
      vote = hot ? int'($urandom_range(20, 50)) : int'($urandom_range(0, 30));
      flag = hot ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) != 0);
      ak   = ($urandom_range(0, 24) == 0);
      r    = ($urandom_range(0, 1499) == 0);
      drive(dv, vote, flag, ak, r);
    end
    idle(2);
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
